time_entry_shifter: RTL and testbench

- Upstream feeder for the microwave timer digit counters: collects keypad digits into an mm:ss BCD image and issues a one-cycle load strobe on START.
- Digits shift in right-to-left, like a calculator, e.g. keys 1,3,0 give 01:30.
- Validates the entered time before loading; on START, the counter chain's parallel inputs are driven from this block's digit outputs.

---
 rtl/time_entry_shifter.sv | 106 ++++++++++
 tb/tb_time_entry_shifter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/time_entry_shifter.sv
// time_entry_shifter: keypad mm:ss entry with validated load strobe; AUTO_NORMALIZE_EN folds 60-99 s into minutes
module time_entry_shifter #(
  parameter int          MAX_DIGITS = 4,
  parameter logic [3:0]  START_CODE = 4'hA,
  parameter logic [3:0]  CLEAR_CODE = 4'hB
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       load,
  output logic       entry_active,
  output logic       error
);
  typedef enum logic [1:0] {IDLE, ENTRY, READY} state_t;
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);
  state_t r_state, w_state_nx;
  logic [3:0] r_mt, r_mu, r_st, r_su, w_mt_nx, w_mu_nx, w_st_nx, w_su_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic r_load, w_load_nx, r_error, w_error_nx;
  logic w_digit, w_start, w_clear, w_zero;
  assign w_digit = key_valid && (key_code <= 4'd9);
  assign w_start = key_valid && (key_code == START_CODE);
  assign w_clear = key_valid && (key_code == CLEAR_CODE);
  assign w_zero  = ~|{r_mt, r_mu, r_st, r_su};
`ifdef AUTO_NORMALIZE_EN
  logic w_ovf;
  logic [3:0] w_nmt, w_nmu, w_nst;
  assign w_ovf = (r_mt == 4'd9) && (r_mu == 4'd9);
  assign w_nmu = (r_mu == 4'd9) ? 4'd0 : r_mu + 4'd1;
  assign w_nmt = (r_mu == 4'd9) ? r_mt + 4'd1 : r_mt;
  assign w_nst = r_st - 4'd6;
`endif
  always_comb begin
    w_state_nx = r_state;
    w_mt_nx    = r_mt;
    w_mu_nx    = r_mu;
    w_st_nx    = r_st;
    w_su_nx    = r_su;
    w_cnt_nx   = r_cnt;
    w_error_nx = r_error;
    w_load_nx  = 1'b0;
    if (w_clear) begin
      {w_mt_nx, w_mu_nx, w_st_nx, w_su_nx} = '0;
      w_cnt_nx   = '0;
      w_error_nx = 1'b0;
      w_state_nx = IDLE;
    end else if (w_digit) begin
      if (r_state == READY) begin
        {w_mt_nx, w_mu_nx, w_st_nx, w_su_nx} = {12'd0, key_code};
        w_cnt_nx   = 3'd1;
        w_error_nx = 1'b0;
        w_state_nx = ENTRY;
      end else if (r_cnt < MAX_CNT) begin
        {w_mt_nx, w_mu_nx, w_st_nx, w_su_nx} = {r_mu, r_st, r_su, key_code};
        w_cnt_nx   = r_cnt + 3'd1;
        w_error_nx = 1'b0;
        w_state_nx = ENTRY;
      end
    end else if (w_start) begin
      if (r_state == ENTRY) begin
        if (r_st > 4'd5) begin
`ifdef AUTO_NORMALIZE_EN
          if (w_ovf) w_error_nx = 1'b1;
          else begin
            {w_mt_nx, w_mu_nx, w_st_nx} = {w_nmt, w_nmu, w_nst};
            w_load_nx  = 1'b1;
            w_state_nx = READY;
          end
`else
          w_error_nx = 1'b1;
`endif
        end else if (!w_zero) begin
          w_load_nx  = 1'b1;
          w_state_nx = READY;
        end
      end else if (r_state == READY) begin
        // a restart landing in the load cycle must not stretch the strobe
        w_load_nx = ~r_load;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!clearn) begin
      r_state <= IDLE;
      {r_mt, r_mu, r_st, r_su} <= '0;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      {r_mt, r_mu, r_st, r_su} <= {w_mt_nx, w_mu_nx, w_st_nx, w_su_nx};
      r_cnt   <= w_cnt_nx;
      r_load  <= w_load_nx;
      r_error <= w_error_nx;
    end
  end
  assign {min_tens, min_units, sec_tens, sec_units} = {r_mt, r_mu, r_st, r_su};
  assign load         = r_load;
  assign entry_active = (r_state == ENTRY);
  assign error        = r_error;
endmodule

// File: tb/tb_time_entry_shifter.sv
// tb_time_entry_shifter: randomized and directed checks against a digit-queue model of the keypad entry
module tb_time_entry_shifter;
  logic clk = 1'b0, clearn = 1'b0, key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic load, entry_active, error;
  int checks = 0, errors = 0;
  int q[$];
  int mode = 0;
  bit m_err = 0, m_load = 0;

  time_entry_shifter dut (
    .clk(clk), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
    .load(load), .entry_active(entry_active), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] exp_v();
    logic [15:0] d = 16'd0;
    foreach (q[i]) d = {d[11:0], 4'(q[i])};
    return {d, m_load, mode == 1, m_err};
  endfunction

  function automatic logic [18:0] dut_v();
    return {min_tens, min_units, sec_tens, sec_units, load, entry_active, error};
  endfunction

  function automatic void model(bit v, logic [3:0] k, bit rst);
    bit pl = m_load;
    int p[4] = '{0, 0, 0, 0};
    int mm, ss;
    m_load = 0;
    if (rst) begin
      q.delete(); mode = 0; m_err = 0;
    end else if (v) begin
      if (k == 4'hB) begin
        q.delete(); mode = 0; m_err = 0;
      end else if (k <= 4'd9) begin
        if (mode == 2) q.delete();
        if (q.size() < 4) begin q.push_back(int'(k)); mode = 1; m_err = 0; end
      end else if (k == 4'hA) begin
        if (mode == 1) begin
          foreach (q[i]) p[4 - q.size() + i] = q[i];
          mm = p[0] * 10 + p[1];
          ss = p[2] * 10 + p[3];
          if (ss >= 60) begin
`ifdef AUTO_NORMALIZE_EN
            if (mm == 99) m_err = 1;
            else begin
              mm++; ss -= 60;
              q = {mm / 10, mm % 10, ss / 10, ss % 10};
              m_load = 1; mode = 2;
            end
`else
            m_err = 1;
`endif
          end else if (mm + ss > 0) begin
            m_load = 1; mode = 2;
          end
        end else if (mode == 2 && !pl) m_load = 1;
      end
    end
  endfunction

  task automatic step(input bit v, input logic [3:0] k, input bit rst);
    @(negedge clk);
    key_valid = v; key_code = k; clearn = ~rst;
    @(posedge clk);
    model(v, k, rst);
    #1;
    key_valid = 1'b0; clearn = 1'b1;
  endtask

  task automatic test_reset();
    step(1'b1, 4'h5, 1'b1);
    checks++;
    if (dut_v() !== 19'd0) begin errors++; $display("FAIL reset: got %h want 0", dut_v()); end
    step(1'b0, 4'h0, 1'b0);
    checks++;
    if (dut_v() !== exp_v()) begin errors++; $display("FAIL reset_idle: got %h want %h", dut_v(), exp_v()); end
  endtask

  task automatic test_basic();
    logic [3:0] seq[4] = '{4'd1, 4'd3, 4'd0, 4'hA};
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL basic_key%0d: got %h want %h", i, dut_v(), exp_v()); end
    end
    checks++;
    if ({min_tens, min_units, sec_tens, sec_units, load} !== {16'h0130, 1'b1})
      begin errors++; $display("FAIL basic_load: got %h%h%h%h load %b want 0130 load 1", min_tens, min_units, sec_tens, sec_units, load); end
    step(1'b0, 4'h0, 1'b0);
    checks++;
    if ({load, entry_active, error, sec_tens} !== {3'b000, 4'd3}) begin errors++; $display("FAIL basic_after: got load %b entry %b err %b", load, entry_active, error); end
  endtask

  task automatic test_max_digits();
    logic [3:0] seq[7] = '{4'hB, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hA};
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL max_key%0d: got %h want %h", i, dut_v(), exp_v()); end
    end
    checks++;
    if ({min_tens, min_units, sec_tens, sec_units, load} !== {16'h1234, 1'b1}) begin errors++; $display("FAIL max_load: got %h want 12341", dut_v()); end
  endtask

  task automatic test_invalid();
    logic [3:0] seq[7] = '{4'hB, 4'd7, 4'd5, 4'hA, 4'hC, 4'hA, 4'hB};
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL invalid_key%0d: got %h want %h", i, dut_v(), exp_v()); end
`ifndef AUTO_NORMALIZE_EN
      if (i == 3) begin
        checks++;
        if ({load, entry_active, error} !== 3'b011) begin errors++; $display("FAIL invalid_err: got %b%b%b want 011", load, entry_active, error); end
      end
`endif
    end
    checks++;
    if (dut_v() !== 19'd0) begin errors++; $display("FAIL invalid_clear: got %h want 0", dut_v()); end
  endtask

  task automatic test_zero_entry();
    logic [3:0] seq[4] = '{4'd0, 4'd0, 4'hA, 4'hB};
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL zero_key%0d: got %h want %h", i, dut_v(), exp_v()); end
    end
  endtask

`ifdef AUTO_NORMALIZE_EN
  task automatic test_normalize();
    logic [3:0] seq[11] = '{4'd1, 4'd7, 4'd5, 4'hA, 4'hB, 4'd9, 4'd9, 4'd7, 4'd0, 4'hA, 4'hB};
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL norm_key%0d: got %h want %h", i, dut_v(), exp_v()); end
      if (i == 3) begin
        checks++;
        if (dut_v() !== {16'h0215, 3'b100}) begin errors++; $display("FAIL norm_load: got %h want 0215 load", dut_v()); end
      end
      if (i == 9) begin
        checks++;
        if ({load, error} !== 2'b01) begin errors++; $display("FAIL norm_ovf: got load %b err %b want 0 1", load, error); end
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [3:0] seq[9] = '{4'd1, 4'd3, 4'd0, 4'hA, 4'hA, 4'hA, 4'd4, 4'hA, 4'hB};
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL b2b_key%0d: got %h want %h", i, dut_v(), exp_v()); end
    end
    step(1'b1, 4'd1, 1'b0); step(1'b1, 4'hA, 1'b0); step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'hA, 1'b0);
    checks++;
    if ({load, entry_active} !== 2'b10) begin errors++; $display("FAIL ready_restart: got load %b entry %b want 1 0", load, entry_active); end
    step(1'b1, 4'd4, 1'b0);
    checks++;
    if (dut_v() !== {16'h0004, 3'b010}) begin errors++; $display("FAIL ready_digit: got %h want 0004 entry", dut_v()); end
  endtask

  task automatic test_reset_start();
    step(1'b1, 4'hB, 1'b0); step(1'b1, 4'd4, 1'b0); step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'hA, 1'b1);
    checks++;
    if (dut_v() !== 19'd0) begin errors++; $display("FAIL reset_start: got %h want 0", dut_v()); end
  endtask

  task automatic test_random();
    logic [3:0] k;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    k = 4'hA;
        2:       k = 4'hB;
        3:       k = 4'(12 + $urandom_range(0, 3));
        default: k = 4'($urandom_range(0, 9));
      endcase
      step($urandom_range(0, 3) != 0, k, $urandom_range(0, 59) == 0);
      checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL random_%0d: key %h got %h want %h", n, k, dut_v(), exp_v()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_digits();
    test_invalid();
    test_zero_entry();
`ifdef AUTO_NORMALIZE_EN
    test_normalize();
`endif
    test_back_to_back();
    test_reset_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
